// File: rtl/vt52_uart_pkg.sv
// Shared types and constants for the VT52 serial receive path.
// Optional 8-E-1 framing is selected with VT52_RX_PARITY_EN.
package vt52_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int VOTE_SAMPLE = 9;
  localparam int DATA_BITS   = 8;

  // Majority of three samples; rejects a single noisy sample mid-bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/vt52_rx_fifo.sv
// Synchronous FIFO with occupancy count. DEPTH must be a power of two so
// the pointers wrap naturally. Pop of an empty FIFO is ignored; a push into
// a full FIFO only lands when a pop happens in the same cycle.
module vt52_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  // Head reads as zero when empty so the output has a defined reset value.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vt52_uart_rx.sv
// VT52 UART receiver: synchronizer, 16x oversampling with 3-sample majority
// vote, framing FSM and receive FIFO drained via valid/ready.
// Define VT52_RX_PARITY_EN for 8-E-1 framing with parity checking.
// Handshake: rx_valid is high while the FIFO holds a byte; the head byte in
// rx_data is consumed on any cycle where rx_valid & rx_ready, and rx_data
// holds steady until then.
module vt52_uart_rx #(
  parameter int CLK_DIV    = 54,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       rts_n,
  output logic [2:0] dbg_state
);

  import vt52_uart_pkg::*;

  localparam int CW = 12;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CW-1:0]   div_q, div_d;
  logic [3:0]      samp_q, samp_d;
  logic            s7_q, s7_d, s8_q, s8_d;
  rx_state_t       state_q, state_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            hi_q, hi_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rts_q, rts_d;
`ifdef VT52_RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
`endif

  logic            rx_s, fall, tick, vote, at_vote, at_end;
  logic            push_req, fifo_pop, fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;

  assign rx_s    = sync2_q;
  assign fall    = prev_q & ~rx_s;
  assign tick    = (div_q == CW'(CLK_DIV - 1));
  assign vote    = maj3(s7_q, s8_q, rx_s);
  assign at_vote = tick & (samp_q == 4'(VOTE_SAMPLE));
  assign at_end  = tick & (samp_q == 4'(OVERSAMPLE - 1));

  // Next-state logic for the sampler, framing FSM and status pulses.
  always_comb begin
    sync1_d     = uart_rx;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    samp_d      = samp_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hi_d        = hi_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
`ifdef VT52_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    if (tick) begin
      samp_d = samp_q + 1'b1;
      if (samp_q == 4'(VOTE_SAMPLE - 2)) s7_d = rx_s;
      if (samp_q == 4'(VOTE_SAMPLE - 1)) s8_d = rx_s;
    end
    case (state_q)
      ST_IDLE: begin
        // Re-phase the tick counter on the start edge.
        if (fall) begin
          state_d = ST_START;
          samp_d  = '0;
          div_d   = '0;
        end
      end
      ST_START: begin
        if (at_vote && vote) begin
          state_d = ST_IDLE;
        end else if (at_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
`ifdef VT52_RX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (at_vote) shift_d = {vote, shift_q[7:1]};
        if (at_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef VT52_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef VT52_RX_PARITY_EN
      ST_PARITY: begin
        if (at_vote) par_d = (^shift_q) ^ vote;
        if (at_end)  state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (at_vote) begin
          if (!vote) begin
            frame_err_d = 1'b1;
            hi_d        = 1'b0;
            state_d     = ST_WAIT_IDLE;
          end else begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            state_d = ST_IDLE;
`ifdef VT52_RX_PARITY_EN
            if (par_q) parity_err_d = 1'b1;
            else       push_req     = 1'b1;
`else
            push_req = 1'b1;
`endif
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Require the line high from one tick through the next.
        if (!rx_s) begin
          hi_d = 1'b0;
        end else if (tick) begin
          if (hi_q) state_d = ST_IDLE;
          else      hi_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_pop = rx_valid & rx_ready;

  // Overrun and flow-control status, registered.
  always_comb begin
    overrun_d = push_req & fifo_full & ~fifo_pop;
    rts_d     = (FIFO_DEPTH - int'(fifo_count)) <= RTS_MARGIN;
  end

  // State registers; synchronizer presets to the idle-high level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      div_q       <= '0;
      samp_q      <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      shift_q     <= '0;
      hi_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rts_q       <= 1'b0;
`ifdef VT52_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      div_q       <= div_d;
      samp_q      <= samp_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hi_q        <= hi_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rts_q       <= rts_d;
`ifdef VT52_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  vt52_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (shift_q),
    .pop       (fifo_pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rts_n     = rts_q;
  assign dbg_state = state_q;
`ifdef VT52_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_vt52_uart_rx.sv
// Directed + randomized bench for vt52_uart_rx at CLK_DIV=4, FIFO_DEPTH=16.
// Define VT52_RX_PARITY_EN to exercise 8-E-1 framing.
module tb_vt52_uart_rx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int MARGIN  = 4;
  localparam int BIT     = 16 * CLK_DIV;
`ifdef VT52_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  // Edge (counted from the start-bit drive) that writes the FIFO: 3 cycles
  // of synchronizer/edge detect, then CLK_DIV cycles per 1/16 bit up to and
  // including the stop bit's sample 9.
  localparam int PUSH_EDGE = 3 + CLK_DIV * (16 * STOP_IDX + 9 + 1);

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, rts_n;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  vt52_uart_rx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH),
    .RTS_MARGIN (MARGIN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .rts_n      (rts_n),
    .dbg_state  (dbg_state)
  );

  // ---------------- monitor ----------------
  logic [7:0] got_q[$];
  int valid_cyc, fe_cnt, pe_cnt, ov_cnt;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) valid_cyc++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun)    ov_cnt++;
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [7:0] mq[$];     // model of FIFO contents
  logic [7:0] exp_q[$];  // bytes expected at the consumer, in order
  int exp_ovf, got_idx;
  int n_assert, n_fail;
  int v0, f0, p0, o0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else exp_ovf++;
  endtask

  task automatic model_drain();
    while (mq.size() > 0) exp_q.push_back(mq.pop_front());
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size() - got_idx, exp_q.size());
    while (exp_q.size() > 0 && got_idx < got_q.size()) begin
      check(tag, 32'(got_q[got_idx]), 32'(exp_q.pop_front()));
      got_idx++;
    end
    exp_q.delete();
    got_idx = got_q.size();
  endtask

  task automatic snap();
    v0 = valid_cyc; f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
  endtask

  task automatic check_no_pulses(input string tag);
    check({tag, "_frame_err"}, fe_cnt - f0, 0);
    check({tag, "_parity_err"}, pe_cnt - p0, 0);
    check({tag, "_overrun"}, ov_cnt - o0, 0);
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    wait_cyc(BIT);
  endtask

  // One frame: start, 8 data bits LSB first, [parity], stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_bad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef VT52_RX_PARITY_EN
    drive_bit((^d) ^ par_bad);
`else
    if (par_bad) $display("note: parity flip ignored in 8-N-1 build");
`endif
    drive_bit(stop_v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    reset_n = 1'b0;
    uart_rx = 1'b1;
    rx_ready = 1'b0;
    wait_cyc(5);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rts_n", 32'(rts_n), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_parity_err", 32'(parity_err), 0);
    check("reset_overrun", 32'(overrun), 0);
    reset_n = 1'b1;
    wait_cyc(5);

    // Single byte with consumer ready.
    rx_ready = 1'b1;
    snap();
    send_frame(8'h41, 1'b1, 1'b0);
    wait_cyc(2 * BIT);
    model_push(8'h41); model_drain();
    check_stream("byte_41");
    check("valid_width_41", valid_cyc - v0, 1);
    check_no_pulses("byte_41");

    // Short low glitch: false start.
    snap();
    uart_rx = 1'b0;
    wait_cyc(3 * CLK_DIV);
    uart_rx = 1'b1;
    wait_cyc(3 * BIT);
    check("glitch_valid", 32'(rx_valid), 0);
    check_stream("glitch");
    check_no_pulses("glitch");

    // Bad stop bit followed by a long break, then a good byte.
    snap();
    send_frame(8'h55, 1'b0, 1'b0);
    wait_cyc(30 * BIT);
    uart_rx = 1'b1;
    wait_cyc(2 * BIT);
    check("break_frame_err", fe_cnt - f0, 1);
    check_stream("break");
    send_frame(8'h0D, 1'b1, 1'b0);
    wait_cyc(2 * BIT);
    model_push(8'h0D); model_drain();
    check_stream("after_break");
    check("after_break_frame_err", fe_cnt - f0, 1);

    // Fill with consumer stalled: 17 back-to-back bytes.
    rx_ready = 1'b0;
    snap();
    exp_ovf = 0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_push(8'(i));
      if (i == 10) check("rts_after_11", 32'(rts_n), 0);
      if (i == 11) check("rts_after_12", 32'(rts_n), 1);
    end
    wait_cyc(BIT);
    check("overrun_once", ov_cnt - o0, exp_ovf);
    check("overrun_model_one", exp_ovf, 1);
    check("full_head_stable", 32'(rx_data), 32'(mq[0]));
    check("full_valid", 32'(rx_valid), 1);

    // Full FIFO, pop coincident with push of 0x7E.
    snap();
    fork
      send_frame(8'h7E, 1'b1, 1'b0);
      begin
        repeat (PUSH_EDGE - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    exp_q.push_back(mq.pop_front());
    model_push(8'h7E);
    wait_cyc(2 * BIT);
    check("simul_no_overrun", ov_cnt - o0, 0);
    check("simul_still_full_rts", 32'(rts_n), 1);
    check_stream("simul_pop");
    rx_ready = 1'b1;
    wait_cyc(4 * DEPTH);
    model_drain();
    check_stream("drain");
    check("drain_valid", 32'(rx_valid), 0);
    wait_cyc(4);
    check("drain_rts", 32'(rts_n), 0);

`ifdef VT52_RX_PARITY_EN
    // Parity: wrong parity bit discarded, correct one received.
    snap();
    send_frame(8'h03, 1'b1, 1'b1);
    wait_cyc(2 * BIT);
    check("parity_bad_pulse", pe_cnt - p0, 1);
    check_stream("parity_bad");
    send_frame(8'h03, 1'b1, 1'b0);
    wait_cyc(2 * BIT);
    model_push(8'h03); model_drain();
    check_stream("parity_good");
    check("parity_good_pulse", pe_cnt - p0, 1);
`endif

    // Random bytes, random gaps, random consumer stalls.
    snap();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_ready = 1'($urandom_range(0, 1));
      send_frame(b, 1'b1, 1'b0);
      model_push(b);
      wait_cyc($urandom_range(0, 2 * BIT));
    end
    rx_ready = 1'b1;
    wait_cyc(2 * BIT);
    model_drain();
    check_stream("random");
    check_no_pulses("random");

    // Reset in the middle of a frame aborts it.
    snap();
    uart_rx = 1'b0;
    wait_cyc(BIT);
    drive_bit(1'b1);
    drive_bit(1'b0);
    wait_cyc(BIT / 2);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(12 * BIT);
    check("midreset_valid", 32'(rx_valid), 0);
    check_stream("midreset");
    check_no_pulses("midreset");
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_cyc(2 * BIT);
    model_push(8'h5A); model_drain();
    check_stream("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
